// File: rtl/rr_mux8_arbiter_if.sv
`default_nettype none
// rr_mux8_arbiter_if: request/data bus and grant/mux outputs of the 8-way round-robin mux arbiter.
interface rr_mux8_arbiter_if;
  logic [7:0] req;
  logic [7:0] data_in;
  logic [7:0] grant;
  logic [2:0] sel;
  logic       busy;
  logic       out;
  logic       out_valid;

  modport master (
    output req, data_in,
    input  grant, sel, busy, out, out_valid
  );

  modport slave (
    input  req, data_in,
    output grant, sel, busy, out, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/rr_mux8_arbiter.sv
`default_nettype none
// rr_mux8_arbiter: round-robin owner selection for a shared 8:1 single-bit mux, with a
// per-owner hold limit and a registered muxed output.
module rr_mux8_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input logic               clk,
  input logic               rst,
  rr_mux8_arbiter_if.slave  bus
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic [2:0]    ptr, ptr_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic [7:0]    grant_q, grant_nxt;
  logic [2:0]    sel_q, sel_nxt;
  logic          busy_q, busy_nxt;
  logic          out_q, valid_q;

  logic [7:0]    owner_mask;
  logic [2:0]    start;
  logic [7:0]    cand;
  logic          found;
  logic [2:0]    winner;
  logic [2:0]    idx;

  // While busy the search begins just after the owner and never re-picks it, which covers
  // both the release and the timeout hand-off with one priority scan.
  assign owner_mask = 8'(1) << sel_q;
  assign start      = (state == BUSY) ? sel_q + 3'd1 : ptr;
  assign cand       = (state == BUSY) ? (bus.req & ~owner_mask) : bus.req;

  always_comb begin
    found  = 1'b0;
    winner = start;
    idx    = '0;
    for (int k = 0; k < 8; k++) begin
      idx = start + 3'(k);
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    hold_nxt  = hold_cnt;
    grant_nxt = grant_q;
    sel_nxt   = sel_q;
    busy_nxt  = busy_q;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = 8'(1) << winner;
          sel_nxt   = winner;
          busy_nxt  = 1'b1;
          hold_nxt  = '0;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (!bus.req[sel_q]) begin
          ptr_nxt  = sel_q + 3'd1;
          hold_nxt = '0;
          if (found) begin
            grant_nxt = 8'(1) << winner;
            sel_nxt   = winner;
          end else begin
            grant_nxt = '0;
            sel_nxt   = '0;
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
          end
        end else if (hold_cnt == HOLD_LAST) begin
          // With no competitor the owner keeps the channel and the count stays saturated.
          if (found) begin
            ptr_nxt   = sel_q + 3'd1;
            grant_nxt = 8'(1) << winner;
            sel_nxt   = winner;
            hold_nxt  = '0;
          end
        end else begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      grant_q  <= '0;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      out_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      hold_cnt <= hold_nxt;
      grant_q  <= grant_nxt;
      sel_q    <= sel_nxt;
      busy_q   <= busy_nxt;
      out_q    <= busy_q ? bus.data_in[sel_q] : 1'b0;
      valid_q  <= busy_q;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.sel       = sel_q;
  assign bus.busy      = busy_q;
  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_mux8_arbiter.sv
`default_nettype none
// tb_rr_mux8_arbiter: directed vector table plus hand sequences for rotation, sole owner and reset.
module tb_rr_mux8_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  rr_mux8_arbiter_if bus ();

  rr_mux8_arbiter #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [7:0] din;
    logic [7:0] g;
    logic [2:0] s;
    logic       b;
    logic       o;
    logic       v;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] g, input logic [2:0] s,
                           input logic b, input logic o, input logic v);
    check({tag, ".grant"}, bus.grant, g);
    check({tag, ".sel"}, 8'(bus.sel), 8'(s));
    check({tag, ".busy"}, 8'(bus.busy), 8'(b));
    check({tag, ".out"}, 8'(bus.out), 8'(o));
    check({tag, ".out_valid"}, 8'(bus.out_valid), 8'(v));
  endtask

  task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] d);
    rst         = r;
    bus.req     = rq;
    bus.data_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] din;
    logic [2:0] prev_sel;
    logic [2:0] exp_sel;

    bus.req     = '0;
    bus.data_in = '0;

    //          rst   req    din    grant  sel   busy  out   valid
    tbl[0]  = '{1'b1, 8'hFF, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'hFF, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'hFF, 8'hFF, 8'h01, 3'd0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 8'hFF, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'h08, 8'h08, 8'h08, 3'd3, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 8'h08, 8'h08, 8'h08, 3'd3, 1'b1, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 8'h08, 8'h00, 8'h08, 3'd3, 1'b1, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 8'h08, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h04, 8'h04, 8'h04, 3'd2, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'h21, 8'h24, 8'h20, 3'd5, 1'b1, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 8'h01, 8'h00, 8'h01, 3'd0, 1'b1, 1'b0, 1'b1};
    tbl[13] = '{1'b0, 8'h00, 8'h01, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].din);
      check_all($sformatf("vec%0d", i), tbl[i].g, tbl[i].s, tbl[i].b, tbl[i].o, tbl[i].v);
    end

    // Sole requester from ptr=1: keeps the grant past the hold limit, then releases (ptr -> 7).
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 8'h40, 8'h00);
      check($sformatf("sole%0d.grant", i), bus.grant, 8'h40);
      check($sformatf("sole%0d.busy", i), 8'(bus.busy), 8'h01);
    end
    step(1'b0, 8'h00, 8'h00);
    check("sole_rel.grant", bus.grant, 8'h00);
    check("sole_rel.busy", 8'(bus.busy), 8'h00);

    // Reset mid-grant: owner 6, then a one-cycle reset must bring ptr back to 0.
    step(1'b0, 8'h40, 8'h40);
    check_all("own6", 8'h40, 3'd6, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h40, 8'h40);
    check_all("midrst", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h81, 8'h00);
    check_all("postrst", 8'h01, 3'd0, 1'b1, 1'b0, 1'b0);

    // Rotation with everyone requesting: each owner held exactly 4 cycles, no idle gap.
    step(1'b1, 8'hFF, 8'h00);
    step(1'b1, 8'hFF, 8'h00);
    check_all("rot_rst", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    din      = 8'hAA;
    prev_sel = 3'd0;
    for (int k = 0; k < 36; k++) begin
      step(1'b0, 8'hFF, din);
      exp_sel = 3'((k / 4) % 8);
      check($sformatf("rot%0d.sel", k), 8'(bus.sel), 8'(exp_sel));
      check($sformatf("rot%0d.grant", k), bus.grant, 8'(1) << exp_sel);
      check($sformatf("rot%0d.busy", k), 8'(bus.busy), 8'h01);
      if (k > 0) begin
        check($sformatf("rot%0d.out", k), 8'(bus.out), 8'(din[prev_sel]));
        check($sformatf("rot%0d.valid", k), 8'(bus.out_valid), 8'h01);
      end
      prev_sel = exp_sel;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
